// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one prescaled sawtooth/triangle counter shared by
// all channels, each channel with a double-buffered duty register.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic                      center_mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       duty_we,
    output logic [CHANNELS-1:0]       pulse,
    output logic                      period_start
);
    localparam logic [WIDTH-1:0]   MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0]   ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO   = '0;
    localparam logic [PRESC_W-1:0] P_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] P_ZERO = '0;

    logic [PRESC_W-1:0]  r_pcnt;
    logic [WIDTH-1:0]    r_cnt;
    logic                r_dir_down;
    logic                r_mode_act;
    logic [WIDTH-1:0]    r_pending [CHANNELS];
    logic [WIDTH-1:0]    r_active  [CHANNELS];
    logic [CHANNELS-1:0] r_pulse;
    logic                r_period_start;

    logic                w_tick;
    logic                w_boundary;
    logic                w_dir_next;
    logic [WIDTH-1:0]    w_cnt_next;
    logic [WIDTH-1:0]    w_duty_next [CHANNELS];
    logic [CHANNELS-1:0] w_level;

    // >= so that lowering prescale below the running count ticks immediately.
    assign w_tick     = enable && (r_pcnt >= prescale);
    assign w_boundary = w_tick && (r_mode_act ? (r_dir_down && (r_cnt == ONE))
                                              : (r_cnt == MAX));

    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        if (w_boundary) begin
            w_cnt_next = ZERO;
            w_dir_next = 1'b0;
        end else if (w_tick) begin
            if (r_mode_act && r_dir_down) begin
                w_cnt_next = r_cnt - ONE;
            end else begin
                w_cnt_next = r_cnt + ONE;
                // dir holds the direction of the next step, so it flips on arrival at MAX.
                if (r_mode_act && (r_cnt == MAX_M1)) begin
                    w_dir_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_duty_next[i] = duty_we[i] ? duty[i*WIDTH +: WIDTH] : r_pending[i];
            if (r_active[i] == MAX) begin
                w_level[i] = 1'b1;
            end else begin
                w_level[i] = (r_cnt < r_active[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt         <= P_ZERO;
            r_cnt          <= ZERO;
            r_dir_down     <= 1'b0;
            r_mode_act     <= 1'b0;
            r_pulse        <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= ZERO;
                r_active[i]  <= ZERO;
            end
        end else if (!enable) begin
            // Stopped: keep the live config tracking so a restart begins cleanly.
            r_pcnt         <= P_ZERO;
            r_cnt          <= ZERO;
            r_dir_down     <= 1'b0;
            r_mode_act     <= center_mode;
            r_pulse        <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= w_duty_next[i];
                r_active[i]  <= r_pending[i];
            end
        end else begin
            r_pcnt         <= w_tick ? P_ZERO : r_pcnt + P_ONE;
            r_cnt          <= w_cnt_next;
            r_dir_down     <= w_dir_next;
            r_pulse        <= w_level;
            r_period_start <= w_boundary;
            if (w_boundary) begin
                r_mode_act <= center_mode;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= w_duty_next[i];
                if (w_boundary) begin
                    r_active[i] <= w_duty_next[i];
                end
            end
        end
    end

    assign pulse        = r_pulse;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-phase reference model compared every cycle, plus
// directed scenarios with hand-computed period lengths and high-time counts.
module tb_pwm_multi;
    localparam int W    = 8;
    localparam int CH   = 4;
    localparam int PW   = 8;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          center_mode = 1'b0;
    logic [CH*W-1:0] duty = '0;
    logic [CH-1:0] duty_we = '0;
    logic [CH-1:0] pulse;
    logic          period_start;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .duty         (duty),
        .duty_we      (duty_we),
        .pulse        (pulse),
        .period_start (period_start)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period (phase) instead of counter+direction.
    int          m_pcnt;
    int          m_ph;
    bit          m_mode;
    int          m_pend [CH];
    int          m_act  [CH];
    int          m_c;
    bit          m_tick;
    bit          m_bnd;
    logic [CH-1:0] exp_pulse;
    logic          exp_ps;

    function automatic int period_len(input bit md);
        return md ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int cnt_of(input int ph, input bit md);
        return (md && ph > MAXV) ? 2 * MAXV - ph : ph;
    endfunction

    function automatic bit level(input int a, input int c);
        if (a == MAXV) return 1'b1;
        if (a == 0) return 1'b0;
        return c < a;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_pcnt = 0;
            m_ph = 0;
            m_mode = 1'b0;
            exp_pulse = '0;
            exp_ps = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 0;
                m_act[i] = 0;
            end
        end else begin
            m_c = cnt_of(m_ph, m_mode);
            for (int i = 0; i < CH; i++) exp_pulse[i] = enable && level(m_act[i], m_c);
            if (!enable) begin
                m_pcnt = 0;
                m_ph = 0;
                exp_ps = 1'b0;
                m_mode = center_mode;
                for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
            end else begin
                m_tick = (m_pcnt >= int'(prescale));
                m_bnd  = m_tick && (m_ph == period_len(m_mode) - 1);
                exp_ps = m_bnd;
                m_pcnt = m_tick ? 0 : m_pcnt + 1;
                if (m_bnd) begin
                    m_ph = 0;
                    m_mode = center_mode;
                    for (int i = 0; i < CH; i++)
                        m_act[i] = duty_we[i] ? int'(duty[i*W +: W]) : m_pend[i];
                end else if (m_tick) begin
                    m_ph = m_ph + 1;
                end
            end
            for (int i = 0; i < CH; i++)
                if (duty_we[i]) m_pend[i] = int'(duty[i*W +: W]);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("pulse", 32'(pulse), 32'(exp_pulse));
            check("period_start", 32'(period_start), 32'(exp_ps));
        end
    end

    int m_hi [CH];
    int m_hi_h1;

    task automatic drive_duty(input int ch, input int val);
        duty[ch*W +: W] = W'(val);
        duty_we[ch] = 1'b1;
        @(negedge clk);
        duty_we = '0;
    endtask

    // Runs until the next period_start (inclusive), counting high cycles per channel.
    // Optional action at cycle act_at: 1 = duty write, 2 = center_mode, 3 = prescale.
    task automatic measure(input int budget, input int half, input int act_at,
                           input int act_kind, input int act_ch, input int act_val,
                           output int period);
        period = 0;
        m_hi_h1 = 0;
        for (int c = 0; c < CH; c++) m_hi[c] = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            duty_we = '0;
            for (int c = 0; c < CH; c++) if (pulse[c] === 1'b1) m_hi[c]++;
            if (n <= half && pulse[0] === 1'b1) m_hi_h1++;
            if (n == act_at) begin
                case (act_kind)
                    1: begin
                        duty[act_ch*W +: W] = W'(act_val);
                        duty_we[act_ch] = 1'b1;
                    end
                    2: center_mode = act_val[0];
                    3: prescale = PW'(act_val);
                    default: ;
                endcase
            end
            if (period_start === 1'b1) begin
                period = n;
                break;
            end
        end
        duty_we = '0;
        if (period == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL period_timeout: no period_start within %0d clks", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset_pulse", 32'(pulse), 0);
        check("reset_period_start", 32'(period_start), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Edge mode, prescale 0, ch0 duty 64 loaded while stopped.
        drive_duty(0, 64);
        @(negedge clk);
        enable = 1'b1;
        measure(600, 0, 0, 0, 0, 0, p);
        check("t1_first_period", p, 256);
        check("t1_first_hi0", m_hi[0], 64);
        measure(600, 0, 0, 0, 0, 0, p);
        check("t1_period", p, 256);
        check("t1_hi0", m_hi[0], 64);

        // 0% and 100% channels across several wraps.
        drive_duty(1, 0);
        drive_duty(2, 255);
        measure(600, 0, 0, 0, 0, 0, p);
        for (int k = 0; k < 3; k++) begin
            measure(600, 0, 0, 0, 0, 0, p);
            check("t2_period", p, 256);
            check("t2_hi1_zero", m_hi[1], 0);
            check("t2_hi2_full", m_hi[2], 256);
        end

        // Mid-period write holds until the boundary; boundary-coincident write goes live at once.
        measure(600, 0, 100, 1, 0, 192, p);
        check("t3_keep_old", m_hi[0], 64);
        measure(600, 0, 0, 0, 0, 0, p);
        check("t3_new", m_hi[0], 192);
        measure(600, 0, 255, 1, 0, 32, p);
        check("t3_coinc_period", p, 256);
        check("t3_coinc_old", m_hi[0], 192);
        measure(600, 0, 0, 0, 0, 0, p);
        check("t3_coinc_new", m_hi[0], 32);

        // Center mode, prescale 3, duty 100.
        prescale = 8'd3;
        center_mode = 1'b1;
        drive_duty(0, 100);
        measure(3000, 0, 0, 0, 0, 0, p);
        measure(2200, 1020, 0, 0, 0, 0, p);
        check("t4_period", p, 2040);
        check("t4_hi0", m_hi[0], 796);
        check("t4_hi0_first_half", m_hi_h1, 400);
        check("t4_hi2_full", m_hi[2], 2040);

        // Mode toggle mid-period applies at the next boundary only.
        measure(2200, 0, 500, 2, 0, 0, p);
        check("t5_toggle_period", p, 2040);
        check("t5_toggle_hi0", m_hi[0], 796);
        measure(1200, 0, 0, 0, 0, 0, p);
        check("t5_edge_period", p, 1024);
        check("t5_edge_hi0", m_hi[0], 400);
        // prescale 200 -> 2 with pcnt at 150: tick on the next clock.
        prescale = 8'd200;
        measure(2000, 0, 150, 3, 0, 2, p);
        check("t5_presc_drop_period", p, 916);
        check("t5_presc_drop_hi0", m_hi[0], 448);
        measure(1000, 0, 0, 0, 0, 0, p);
        check("t5_presc2_period", p, 768);
        check("t5_presc2_hi0", m_hi[0], 300);

        // Disable mid-period, reconfigure, restart from cnt 0.
        repeat (50) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t6_dis_pulse", 32'(pulse), 0);
        check("t6_dis_period_start", 32'(period_start), 0);
        drive_duty(3, 10);
        prescale = 8'd0;
        @(negedge clk);
        enable = 1'b1;
        measure(600, 0, 0, 0, 0, 0, p);
        check("t6_restart_period", p, 256);
        check("t6_restart_hi3", m_hi[3], 10);
        check("t6_restart_hi0", m_hi[0], 100);
        check("t6_restart_hi2", m_hi[2], 256);

        // Asynchronous reset mid-period.
        repeat (77) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_pulse", 32'(pulse), 0);
        check("t6_rst_period_start", 32'(period_start), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        measure(600, 0, 0, 0, 0, 0, p);
        check("t6_after_rst_period", p, 256);
        check("t6_after_rst_hi2", m_hi[2], 0);
        drive_duty(2, 255);
        measure(600, 0, 0, 0, 0, 0, p);
        measure(600, 0, 0, 0, 0, 0, p);
        check("t6_after_rst_hi2_full", m_hi[2], 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
